reg_file_loader: RTL and testbench
==================================

Name: reg_file_loader

Overview:
- Upstream feeder for the two-entry 16-bit register file.
- Accepts a stream of 16-bit words over a valid/ready handshake and packs consecutive pairs into one 32-bit write, with the first word in the low half.
- Buffers the packed writes in a small FIFO and presents them to the register file as single-cycle write-enable pulses with data. A downstream ready input throttles the writes.

Parameters:
- FIFO_DEPTH, 2, number of packed 32-bit entries buffered; must be a power of 2 and at least 2.
- PTR_W, 1, pointer width, equal to log2(FIFO_DEPTH); count width is PTR_W+1.

Ports:
- clock  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock
- in_valid  in  1  upstream word valid
- in_ready  out  1  loader can accept a word this cycle
- in_data  in  16  upstream word
- in_last  in  1  marks the final word of a burst; forces a flush of a lone low half
- w_ready_in  in  1  register file may take a write this cycle
- w_en_out  out  1  write-enable pulse to the register file
- w_data_out  out  32  write data; bits [15:0] are register 0, bits [31:16] are register 1
- busy_out  out  1  a half-word is held or the FIFO is non-empty

Behaviour:
- Accept: a word is accepted when in_valid and in_ready are both 1.
- in_ready = (count < FIFO_DEPTH). It is combinational from registered state only, never from in_valid.
- Pack FSM, two states: S_LO (no half held) and S_HI (low half held in lo_reg).
- S_LO, accept, in_last=0: lo_reg <= in_data; next state S_HI; nothing pushed.
- S_LO, accept, in_last=1: push {16'h0000, in_data}; stay in S_LO.
- S_HI, accept: push {in_data, lo_reg}; next state S_LO. in_last is ignored, since the pair is complete.
- No accept: state and lo_reg hold.
- FIFO: circular buffer with wr_ptr, rd_ptr and count; both pointers wrap modulo FIFO_DEPTH.
- w_en_out = (count != 0) && w_ready_in. This is combinational; a pop occurs in every cycle w_en_out = 1.
- w_data_out = FIFO head when count != 0, otherwise 32'h0.
- Latency: an entry pushed at the edge ending cycle N gives w_en_out = 1 in cycle N+1 if w_ready_in = 1 then. There is no bypass within the same cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full: in_ready = 0 and no word is accepted. This holds even in S_LO, where the accept would not push.
- w_ready_in = 0: the head entry and w_data_out stay stable and w_en_out = 0.
- busy_out = (state == S_HI) || (count != 0).
- Reset (reset = 0 at a rising edge), including mid-operation:
  - state <= S_LO, lo_reg <= 0, wr_ptr/rd_ptr/count <= 0.
  - A half-word held at reset is discarded.
  - Outputs after the edge: w_en_out = 0, w_data_out = 0, busy_out = 0, in_ready = 1.
  - Words presented while reset = 0 are not accepted.

Optional Feature:
- Macro: LOADER_WR_COUNT_EN.
- Defined:
  - Adds output wr_count_out[15:0].
  - Increments by 1 on every cycle w_en_out = 1 and wraps from 16'hFFFF to 0.
  - Cleared to 0 by reset.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release -> in_ready=1, w_en_out=0, w_data_out=0, busy_out=0.
- Pair pack: w_ready_in=1; accept 16'h1111 then 16'h2222 in consecutive cycles -> exactly one w_en_out pulse, one cycle after the second accept, with w_data_out=32'h2222_1111.
- Lone flush: accept 16'hABCD with in_last=1 -> next cycle w_en_out=1, w_data_out=32'h0000_ABCD; FSM stays in S_LO.
- Backpressure/full (FIFO_DEPTH=2):
  - Hold w_ready_in=0 and stream 6 words -> 4 accepted, then in_ready=0.
  - Raise w_ready_in -> two pulses in order carrying the first and second pairs.
  - in_ready returns to 1 one cycle after the first pop.
- Simultaneous push and pop: count=1 with w_ready_in=1, completing a pair in the same cycle -> count stays 1 and the data order is preserved.
- Reset mid-pair: accept 16'h5555 (S_HI), assert reset=0 for one edge, then accept 16'h0001 and 16'h0002 -> single write 32'h0002_0001 and no trace of 16'h5555. With LOADER_WR_COUNT_EN defined, wr_count_out=1 after this sequence.

Source files
------------

// File: rtl/reg_file_loader_if.sv
// reg_file_loader_if
//   Handshake bundle between a 16-bit word producer, the loader and the
//   two-entry register file write port.
//   master : environment side (drives words and write-ready)
//   slave  : loader side (drives in_ready and the write pulse/data)
//   Signals:
//     in_valid/in_ready/in_data/in_last : upstream word stream
//     w_ready_in                        : register file can take a write
//     w_en_out/w_data_out               : single-cycle write pulse + 32-bit data
interface reg_file_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        w_ready_in;
  logic        w_en_out;
  logic [31:0] w_data_out;

  modport master (
    output in_valid, in_data, in_last, w_ready_in,
    input  in_ready, w_en_out, w_data_out
  );

  modport slave (
    input  in_valid, in_data, in_last, w_ready_in,
    output in_ready, w_en_out, w_data_out
  );
endinterface

// File: rtl/reg_file_loader.sv
// reg_file_loader
//   Packs pairs of 16-bit words into 32-bit register-file writes (first word
//   in the low half), buffers them in a small FIFO and drains the FIFO as
//   write-enable pulses throttled by w_ready_in. A word flagged in_last that
//   arrives with no half held is flushed alone, zero-extended.
// Ports:
//   clock        : single rising-edge clock
//   reset        : synchronous, active-low
//   bus (slave)  : word stream in, write pulse/data out (see reg_file_loader_if)
//   busy_out     : a half-word is held or the FIFO holds entries
//   wr_count_out : (LOADER_WR_COUNT_EN only) wrapping count of issued writes
// Parameters:
//   FIFO_DEPTH   : packed entries buffered, power of 2, >= 2
//   PTR_W        : log2(FIFO_DEPTH)
// Optional feature macro: LOADER_WR_COUNT_EN
module reg_file_loader #(
  parameter int FIFO_DEPTH = 2,
  parameter int PTR_W      = 1
) (
  input  logic               clock,
  input  logic               reset,
  reg_file_loader_if.slave   bus,
  output logic               busy_out
`ifdef LOADER_WR_COUNT_EN
  ,
  output logic [15:0]        wr_count_out
`endif
);

  typedef enum logic {S_LO = 1'b0, S_HI = 1'b1} state_t;

  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = (PTR_W)'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [15:0]       r_lo;
  logic [31:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;

  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_lo_load;
  logic [31:0]       w_push_data;
  logic              w_not_empty;

  // in_ready looks only at registered occupancy, so a full FIFO stalls the
  // stream even when the incoming word would only be parked in r_lo.
  assign bus.in_ready = (r_count < DEPTH_C);
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_not_empty  = (r_count != '0);
  assign w_pop        = w_not_empty && bus.w_ready_in;

  assign bus.w_en_out   = w_pop;
  assign bus.w_data_out = w_not_empty ? r_mem[r_rd_ptr] : 32'h0;
  assign busy_out       = (r_state == S_HI) || w_not_empty;

  // ---- pack FSM: state register ----
  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_LO;
    else        r_state <= w_state_nxt;
  end

  // ---- pack FSM: next state ----
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LO: if (w_accept && !bus.in_last) w_state_nxt = S_HI;
      S_HI: if (w_accept)                 w_state_nxt = S_LO;
      default:                            w_state_nxt = S_LO;
    endcase
  end

  // ---- pack FSM: outputs ----
  // in_last only matters with no half held; in S_HI the pair is already
  // complete so it is ignored.
  always_comb begin
    w_push      = 1'b0;
    w_push_data = 32'h0;
    w_lo_load   = 1'b0;
    case (r_state)
      S_LO: begin
        if (w_accept) begin
          if (bus.in_last) begin
            w_push      = 1'b1;
            w_push_data = {16'h0000, bus.in_data};
          end else begin
            w_lo_load = 1'b1;
          end
        end
      end
      S_HI: begin
        if (w_accept) begin
          w_push      = 1'b1;
          w_push_data = {bus.in_data, r_lo};
        end
      end
      default: ;
    endcase
  end

  // ---- low-half holding register ----
  always_ff @(posedge clock) begin
    if (!reset)         r_lo <= 16'h0;
    else if (w_lo_load) r_lo <= bus.in_data;
  end

  // ---- FIFO storage: contents need no reset, w_data_out is gated by count ----
  always_ff @(posedge clock) begin
    if (reset && w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  // ---- FIFO pointers and occupancy ----
  // Pointers are exactly PTR_W bits so the modulo-depth wrap is free.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef LOADER_WR_COUNT_EN
  logic [15:0] r_wr_count;

  // Wraps naturally from 16'hFFFF to 0.
  always_ff @(posedge clock) begin
    if (!reset)     r_wr_count <= 16'h0;
    else if (w_pop) r_wr_count <= r_wr_count + 16'd1;
  end

  assign wr_count_out = r_wr_count;
`endif

endmodule

// File: tb/tb_reg_file_loader.sv
// Self-checking bench for reg_file_loader. The stimulus process pushes the
// expected write data into a scoreboard queue and the expected status of the
// upcoming cycle into a probe queue; a single negedge monitor does all
// comparisons.
module tb_reg_file_loader;

  logic clock = 1'b0;
  logic reset;
  logic busy_out;
`ifdef LOADER_WR_COUNT_EN
  logic [15:0] wr_count_out;
`endif

  reg_file_loader_if bus ();

  reg_file_loader #(.FIFO_DEPTH(2), .PTR_W(1)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus.slave),
    .busy_out (busy_out)
`ifdef LOADER_WR_COUNT_EN
    ,
    .wr_count_out (wr_count_out)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    string name;
    bit    rdy;
    bit    en;
    bit    busy;
    bit    zero;   // also require w_data_out == 0
  } probe_t;

  logic [31:0] sb_q[$];
  probe_t      probe_q[$];
  int          n_pass  = 0;
  int          n_total = 0;
  bit          done    = 1'b0;
  int          cycles  = 0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic probe(input string name, input bit rdy, input bit en,
                       input bit busy, input bit zero);
    probe_t p;
    p.name = name; p.rdy = rdy; p.en = en; p.busy = busy; p.zero = zero;
    probe_q.push_back(p);
  endtask

  task automatic drive(input logic [15:0] d, input bit last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // ---- monitor: sole owner of the pass/total counters ----
  always @(negedge clock) begin
    cycles++;
    while (probe_q.size() > 0) begin
      probe_t p;
      p = probe_q.pop_front();
      n_total++;
      if (bus.in_ready === p.rdy) n_pass++;
      else $display("FAIL %s in_ready: got %b expected %b", p.name, bus.in_ready, p.rdy);
      n_total++;
      if (bus.w_en_out === p.en) n_pass++;
      else $display("FAIL %s w_en_out: got %b expected %b", p.name, bus.w_en_out, p.en);
      n_total++;
      if (busy_out === p.busy) n_pass++;
      else $display("FAIL %s busy_out: got %b expected %b", p.name, busy_out, p.busy);
      if (p.zero) begin
        n_total++;
        if (bus.w_data_out === 32'h0) n_pass++;
        else $display("FAIL %s w_data_out: got %h expected 00000000", p.name, bus.w_data_out);
      end
    end
    if (bus.w_en_out === 1'b1) begin
      n_total++;
      if (sb_q.size() == 0) begin
        $display("FAIL write_unexpected: got %h expected no write", bus.w_data_out);
      end else begin
        logic [31:0] exp;
        exp = sb_q.pop_front();
        if (bus.w_data_out === exp) n_pass++;
        else $display("FAIL write_data: got %h expected %h", bus.w_data_out, exp);
      end
    end
    if (done || cycles > 2000) begin
      if (!done) begin
        n_total++;
        $display("FAIL watchdog: got %0d cycles expected completion", cycles);
      end
      n_total++;
      if (sb_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
`ifdef LOADER_WR_COUNT_EN
      n_total++;
      if (wr_count_out === 16'd1) n_pass++;
      else $display("FAIL wr_count: got %0d expected 1", wr_count_out);
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
    end
  end

  // ---- stimulus ----
  initial begin
    reset          = 1'b0;
    bus.w_ready_in = 1'b1;
    drive(16'hDEAD, 1'b0);   // presented during reset, must be dropped
    step(); step();
    reset = 1'b1;
    idle();
    probe("reset_idle", 1, 0, 0, 1);
    step();

    // pair pack: 1111 then 2222 -> one write 2222_1111 one cycle later
    drive(16'h1111, 1'b0); probe("pair_w1", 1, 0, 0, 1); step();
    drive(16'h2222, 1'b0); probe("pair_w2", 1, 0, 1, 1);
    sb_q.push_back(32'h2222_1111); step();
    idle();                probe("pair_out", 1, 1, 1, 0); step();
    probe("pair_done", 1, 0, 0, 1); step();

    // lone flush
    drive(16'hABCD, 1'b1); probe("lone_in", 1, 0, 0, 1);
    sb_q.push_back(32'h0000_ABCD); step();
    idle();                probe("lone_out", 1, 1, 1, 0); step();
    probe("lone_slo", 1, 0, 0, 1); step();

    // backpressure: 6 words offered, 4 accepted, FIFO full
    bus.w_ready_in = 1'b0;
    sb_q.push_back(32'hA002_A001);
    sb_q.push_back(32'hA004_A003);
    for (int k = 0; k < 6; k++) begin
      drive(16'hA001 + 16'(k), 1'b0);
      probe($sformatf("bp_word%0d", k), (k < 4), 0, (k > 0), 0);
      step();
    end
    idle();
    probe("full_hold", 0, 0, 1, 0); step();
    bus.w_ready_in = 1'b1;
    probe("drain1", 0, 1, 1, 0); step();
    probe("drain2", 1, 1, 1, 0); step();
    probe("drain_done", 1, 0, 0, 1); step();

    // simultaneous push and pop with one entry queued
    bus.w_ready_in = 1'b0;
    drive(16'hB001, 1'b0); probe("sim_w1", 1, 0, 0, 1); step();
    drive(16'hB002, 1'b0); probe("sim_w2", 1, 0, 1, 1); step();
    drive(16'hB003, 1'b0); probe("sim_w3", 1, 0, 1, 0); step();
    bus.w_ready_in = 1'b1;
    sb_q.push_back(32'hB002_B001);
    sb_q.push_back(32'hB004_B003);
    drive(16'hB004, 1'b0); probe("sim_both", 1, 1, 1, 0); step();
    idle();                probe("sim_after", 1, 1, 1, 0); step();
    probe("sim_done", 1, 0, 0, 1); step();

    // reset mid-pair discards the held half
    drive(16'h5555, 1'b0); probe("rst_half", 1, 0, 0, 1); step();
    idle(); reset = 1'b0;  probe("rst_pre", 1, 0, 1, 1); step();
    reset = 1'b1;          probe("rst_post", 1, 0, 0, 1); step();
    drive(16'h0001, 1'b0); probe("rst_w1", 1, 0, 0, 1); step();
    drive(16'h0002, 1'b0); probe("rst_w2", 1, 0, 1, 1);
    sb_q.push_back(32'h0002_0001); step();
    idle();                probe("rst_out", 1, 1, 1, 0); step();
    probe("rst_done", 1, 0, 0, 1); step();

    done = 1'b1;
  end

endmodule
